// File: rtl/coloring_sched.sv
// Round-robin scheduler sharing one external coloring rule-checker among N_REQ requesters.
// Each granted packet is streamed through the cleared checker and its violations are reported.
module coloring_sched #(
  parameter int N_REQ = 4,
  parameter int LEN_W = 4,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*LEN_W-1:0] req_len,
  input  logic [N_REQ*2-1:0]     req_color,
  output logic [N_REQ-1:0]       gnt,
  output logic                   col_pop,
  output logic                   chk_rst_n,
  output logic [1:0]             chk_color,
  input  logic                   chk_check,
  output logic                   done,
  output logic [ID_W-1:0]        done_id,
  output logic [LEN_W-1:0]       viol_cnt,
  output logic                   pass,
  output logic [2:0]             dbg_state
);

  // Handshake: a requester holds req high with its current color on req_color; it moves to
  // its next color after every edge where gnt[i] & col_pop is high. req is only sampled in IDLE.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam int CW = ID_W + 1;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  win_q, win_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [LEN_W-1:0] viol_q, viol_d;

  logic [N_REQ-1:0] gnt_d;
  logic             col_pop_d, chk_rst_n_d, done_d, pass_d;
  logic [1:0]       chk_color_d;
  logic [ID_W-1:0]  done_id_d;
  logic [LEN_W-1:0] viol_cnt_d;

  logic             win_found;
  logic [ID_W-1:0]  win_id;
  logic [LEN_W-1:0] win_len;
  logic [CW-1:0]    cand;

  assign dbg_state = state_q;

  // First requester at or after ptr, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr_q} + CW'(k);
      if (cand >= CW'(N_REQ)) cand = cand - CW'(N_REQ);
      if (!win_found && req[cand[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = cand[ID_W-1:0];
      end
    end
    win_len = req_len[int'(win_id)*LEN_W +: LEN_W];
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    len_d       = len_q;
    rem_d       = rem_q;
    viol_d      = viol_q;
    gnt_d       = gnt;
    col_pop_d   = 1'b0;
    chk_rst_n_d = 1'b0;
    chk_color_d = chk_color;
    done_d      = 1'b0;
    done_id_d   = done_id;
    viol_cnt_d  = viol_cnt;
    pass_d      = pass;

    if ((state_q == S_STREAM || state_q == S_DRAIN) && chk_check)
      viol_d = viol_q + LEN_W'(1);

    // col_pop runs one cycle ahead of the checker: the color captured on a popping edge is
    // the one the requester shows before advancing, so color k lands in stream cycle k.
    if (col_pop)
      chk_color_d = req_color[int'(win_q)*2 +: 2];

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d        = S_CLEAR;
          win_d          = win_id;
          len_d          = win_len;
          viol_d         = '0;
          gnt_d          = '0;
          gnt_d[win_id]  = 1'b1;
          col_pop_d      = (win_len != '0);
        end
      end
      S_CLEAR: begin
        if (len_q != '0) begin
          state_d     = S_STREAM;
          rem_d       = len_q - LEN_W'(1);
          chk_rst_n_d = 1'b1;
          col_pop_d   = (len_q != LEN_W'(1));
        end else begin
          state_d = S_DONE;
        end
      end
      S_STREAM: begin
        chk_rst_n_d = 1'b1;
        if (rem_q == '0) begin
          state_d = S_DRAIN;
        end else begin
          rem_d     = rem_q - LEN_W'(1);
          col_pop_d = (rem_q != LEN_W'(1));
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Result registers load on entry to DONE so they are valid while done is high.
    if (state_d == S_DONE) begin
      gnt_d      = '0;
      done_d     = 1'b1;
      done_id_d  = win_q;
      viol_cnt_d = viol_d;
      pass_d     = (viol_d == '0);
      ptr_d      = (win_q == ID_W'(N_REQ - 1)) ? '0 : win_q + ID_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      len_q     <= '0;
      rem_q     <= '0;
      viol_q    <= '0;
      gnt       <= '0;
      col_pop   <= 1'b0;
      chk_rst_n <= 1'b0;
      chk_color <= 2'd0;
      done      <= 1'b0;
      done_id   <= '0;
      viol_cnt  <= '0;
      pass      <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      len_q     <= len_d;
      rem_q     <= rem_d;
      viol_q    <= viol_d;
      gnt       <= gnt_d;
      col_pop   <= col_pop_d;
      chk_rst_n <= chk_rst_n_d;
      chk_color <= chk_color_d;
      done      <= done_d;
      done_id   <= done_id_d;
      viol_cnt  <= viol_cnt_d;
      pass      <= pass_d;
    end
  end

endmodule

// File: doc/coloring_sched.md
Name: coloring_sched

Overview:
- Round-robin scheduler that shares one `coloring` rule-checker instance among N_REQ requesters.
- Each requester submits a packet of 2-bit colors (0=red, 1=green, 2=blue).
- For each packet the block clears the checker, streams the colors into it one per cycle, and counts the cycles where `check` is high.
- It then reports a per-packet violation count and a pass flag to the winning requester.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- LEN_W, 4, packet-length width; maximum packet is 2^LEN_W-1 colors.
- ID_W, 2, requester index width; must satisfy 2^ID_W >= N_REQ.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  N_REQ  per-requester packet request, level.
- req_len  in  N_REQ*LEN_W  packed lengths; requester i at bits [i*LEN_W +: LEN_W].
- req_color  in  N_REQ*2  packed current color; requester i at bits [i*2 +: 2].
- gnt  out  N_REQ  one-hot grant, registered.
- col_pop  out  1  granted requester advances to its next color after this edge.
- chk_rst_n  out  1  drives the checker's rst_n, registered, glitch-free.
- chk_color  out  2  drives the checker's color input, registered.
- chk_check  in  1  checker output; registered, reflects the color sampled on the previous edge.
- done  out  1  one-cycle result strobe.
- done_id  out  ID_W  requester index of the finished packet.
- viol_cnt  out  LEN_W  number of violations in the finished packet.
- pass  out  1  high when viol_cnt==0.

Behaviour:
- Reset values: gnt=0, col_pop=0, chk_rst_n=0, chk_color=0, done=0, done_id=0, viol_cnt=0, pass=0. FSM=IDLE, rr pointer=0.
- Reset is asynchronous and may arrive in any state. It aborts the packet with no done strobe. The checker is held in reset because chk_rst_n=0.
- State IDLE:
  - If req!=0, pick the first set bit scanning from ptr upward, with wrap-around.
  - Register the one-hot gnt, latch the winner's length into len_q, clear viol_q, go to CLEAR.
  - If req==0, stay in IDLE.
- State CLEAR (1 cycle):
  - gnt held, chk_rst_n=0.
  - Next state is STREAM if len_q!=0, else DONE.
- State STREAM (len_q cycles):
  - chk_rst_n=1, col_pop=1.
  - chk_color is registered from the granted req_color, so color k reaches the checker in stream cycle k.
  - Down-counter remaining = len_q-1 .. 0; when it reaches 0, go to DRAIN.
- State DRAIN (1 cycle):
  - chk_rst_n=1, col_pop=0.
  - Captures the checker's response to the last color.
- Violation counting: in STREAM and DRAIN, viol_q increments when chk_check=1. No saturation is needed because violations <= len-1.
- State DONE (1 cycle):
  - gnt=0, chk_rst_n=0.
  - done=1, done_id=winner, viol_cnt=viol_q, pass=(viol_q==0).
  - ptr = (winner+1) mod N_REQ, then go to IDLE.
- Output hold: viol_cnt, pass and done_id hold their values until the next DONE.
- chk_rst_n is low in IDLE, CLEAR and DONE, so every packet starts from checker state 0.
- Requester contract: hold req high and present the current color; advance after each edge where gnt[i]&col_pop is high.
- req deasserting mid-packet is ignored; the packet completes using len_q.
- A requester that keeps req high is rearbitrated in the next IDLE. Because ptr moves past it, others win first.
- Packet period is len+4 cycles (IDLE, CLEAR, len×STREAM, DRAIN, DONE).
- Length 0 goes CLEAR->DONE with no col_pop pulse, viol_cnt=0, pass=1.
- gnt is never multi-hot and never changes outside the IDLE->CLEAR and DONE transitions.

Test Plan:
- Requester 0 only, len=2, colors 0,1 -> 2 col_pop cycles, done after 6 cycles, done_id=0, viol_cnt=1, pass=0.
- Requester 2 only, len=4, colors 0,2,1,2 -> viol_cnt=0, pass=1; chk_rst_n low in CLEAR, high for exactly 5 cycles.
- Requester 1 only, len=3, colors 2,2,2 -> viol_cnt=1. Back-to-back len=2, colors 2,2 -> viol_cnt=0, proving the checker is cleared between packets.
- req=4'b1111 held, all len=1 -> grants in order 0,1,2,3,0; each done 5 cycles apart; gnt always one-hot.
- req_len=0 on requester 3 -> no col_pop, done 3 cycles after grant with viol_cnt=0, pass=1.
- rst_n pulsed low mid-STREAM of a len=10 packet -> gnt=0, chk_rst_n=0 immediately, no done strobe; after release, next grant goes to requester 0 (ptr reset).
